id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding selection for the pipelined LEGv8 core.
- Sits directly upstream of the ALU and drives its a, b and ALUControl inputs.
- Captures decoded operands and controls each cycle, honours stall and flush, and resolves RAW hazards from the MEM and WB stages.

Parameters:
N, 64, datapath width
RW, 5, register-index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stage registers
flush  in  1  insert bubble
valid_d  in  1  decode-stage instruction valid
ALUControl_d  in  4  ALU op (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASSB)
readData1_d  in  N  register-file port 1
readData2_d  in  N  register-file port 2
signImm_d  in  N  sign-extended immediate
ALUSrc_d  in  1  1: b comes from the immediate
Rn_d, Rm_d, Rd_d  in  RW each  source/dest indices; Rm carries Rt for stores
RegWrite_d, MemWrite_d, MemRead_d  in  1 each  controls
RegWrite_m  in  1  MEM-stage write enable
Rd_m  in  RW  MEM-stage destination
aluResult_m  in  N  MEM-stage result
RegWrite_w  in  1  WB-stage write enable
Rd_w  in  RW  WB-stage destination
writeData_w  in  N  WB-stage result
a_e  out  N  ALU operand a
b_e  out  N  ALU operand b
ALUControl_e  out  4  ALU op
writeData_e  out  N  store data, after forwarding
Rd_e  out  RW  registered destination
RegWrite_e, MemWrite_e, MemRead_e, valid_e  out  1 each  registered controls
ForwardA, ForwardB  out  2  forwarding select: 00 regfile, 10 MEM, 01 WB

Behaviour:
- Register update on posedge clk, with priority reset > flush > stall > load.
- reset: every stage register clears to 0, so valid_e=0, ALUControl_e=0000, all controls 0 and all data/index registers 0.
- flush: same clearing as reset (bubble); takes priority over a simultaneous stall.
- stall (no flush): all registers hold their values; the _d inputs are ignored.
- load: all _d values are captured. If valid_d=0, RegWrite/MemWrite/MemRead are captured as 0 while data is still captured.
- Latency: inputs captured at edge n appear on the outputs after edge n. Forwarding is combinational on the registered values plus the current _m/_w inputs.
- ForwardA:
  - 10 when RegWrite_m && Rd_m!=31 && Rd_m==Rn_e;
  - else 01 when RegWrite_w && Rd_w!=31 && Rd_w==Rn_e;
  - else 00.
- ForwardB: same rule using Rm_e. MEM takes priority over WB.
- Register 31 (XZR) is never a forwarding source or target.
- fwdA = mux(ForwardA: rd1_e, aluResult_m, writeData_w); fwdB is the same mux over rd2_e.
- a_e = fwdA.
- b_e = ALUSrc_e ? signImm_e : fwdB.
- writeData_e = fwdB always, independent of ALUSrc_e.
- No arithmetic in this block; widths pass through unchanged.
- Reset mid-stall or mid-flush: reset wins in the same cycle.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN
- Defined: forwarding as specified above.
- Undefined:
  - ForwardA = ForwardB = 00 constant;
  - a_e = rd1_e, writeData_e = rd2_e;
  - b_e = ALUSrc_e ? signImm_e : rd2_e;
  - the _m/_w inputs are unused; hazards are the responsibility of the stall logic.

Decomposition:
- Shared package legv8_pkg:
  - alu_op_t enum (AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, PASSB 4'b0111);
  - fwd_sel_t enum (FWD_REG 2'b00, FWD_WB 2'b01, FWD_MEM 2'b10);
  - constant XZR = 31.
- One sub-module, forward_unit: combinational compare of source index against Rd_m/Rd_w with the XZR exclusion; produces fwd_sel_t. Instantiated twice, for A and for B.

Test Plan:
- Reset: hold reset 2 cycles with valid_d=1 and ALUControl_d=0010 -> valid_e=0, ALUControl_e=0000, a_e=b_e=0, all controls 0.
- Plain load: rd1=1206, rd2=4404, ALUControl_d=0000, ALUSrc_d=0, no forwarding -> next cycle a_e=1206, b_e=4404, ForwardA=ForwardB=00; downstream ALU result = 52.
- MEM-over-WB priority: Rn_e=3, RegWrite_m=1, Rd_m=3, aluResult_m=6127, RegWrite_w=1, Rd_w=3, writeData_w=999 -> a_e=6127, ForwardA=10. Then drop RegWrite_m -> a_e=999, ForwardA=01.
- XZR exclusion: Rn_e=31, RegWrite_m=1, Rd_m=31, aluResult_m=52 -> ForwardA=00, a_e=rd1_e.
- Stall then flush: load rd1=4781, then stall 3 cycles while _d changes -> outputs hold 4781. Assert flush together with stall -> valid_e=0, RegWrite_e=0, a_e=0.
- Immediate with store forwarding: ALUSrc_d=1, signImm_d=-8, Rm_d=5, RegWrite_m=1, Rd_m=5, aluResult_m=1346 -> b_e=-8, writeData_e=1346, ForwardB=10.

Source files
------------

// File: rtl/legv8_pkg.sv
// ============================================================================
// Module  : legv8_pkg
// Purpose : Shared types and constants for the pipelined LEGv8 core.
//           - alu_op_t  : 4-bit ALU operation codes driven to the ALU
//           - fwd_sel_t : operand forwarding select (regfile / WB / MEM)
//           - XZR       : index of the zero register, never forwarded
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package legv8_pkg;

  typedef enum logic [3:0] {
    AND   = 4'b0000,
    OR    = 4'b0001,
    ADD   = 4'b0010,
    SUB   = 4'b0110,
    PASSB = 4'b0111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int XZR = 31;

endpackage

`default_nettype wire

// File: rtl/forward_unit.sv
// ============================================================================
// Module  : forward_unit
// Purpose : Combinational RAW-hazard detector for one ALU source operand.
//           Selects the MEM-stage result when the MEM instruction writes the
//           source register, otherwise the WB-stage result when WB writes it,
//           otherwise the register-file value. XZR never forwards.
// Ports   : src          - source register index of the EX instruction
//           reg_write_m  - MEM-stage write enable,  rd_m - MEM destination
//           reg_write_w  - WB-stage write enable,   rd_w - WB destination
//           sel          - forwarding select (fwd_sel_t encoding)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module forward_unit
  import legv8_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic          reg_write_m,
  input  logic [RW-1:0] rd_m,
  input  logic          reg_write_w,
  input  logic [RW-1:0] rd_w,
  output logic [1:0]    sel
);

  localparam logic [RW-1:0] ZERO_REG = RW'(XZR);

  fwd_sel_t sel_int;

  // MEM holds the younger instruction, so its result is checked first.
  always_comb begin
    sel_int = FWD_REG;
    if (reg_write_m && (rd_m != ZERO_REG) && (rd_m == src)) begin
      sel_int = FWD_MEM;
    end else if (reg_write_w && (rd_w != ZERO_REG) && (rd_w == src)) begin
      sel_int = FWD_WB;
    end
  end

  assign sel = sel_int;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Purpose : ID/EX pipeline register with operand forwarding for the ALU.
//           Register priority: reset > flush > stall > load. Forwarding is
//           combinational on the registered sources and the live MEM/WB
//           inputs.
// Config  : ID_EX_FORWARDING_EN - when defined, MEM/WB forwarding is active;
//           when undefined, operands come straight from the registered
//           regfile values and ForwardA/ForwardB are tied to 00.
// Ports   : clk, reset (sync, active-high), stall, flush
//           *_d  - decode-stage operands and controls
//           *_m  - MEM-stage write-back info; *_w - WB-stage write-back info
//           a_e, b_e, ALUControl_e - ALU inputs
//           writeData_e - store data; Rd_e and *_e controls - registered
//           ForwardA/ForwardB - forwarding selects (00 reg, 10 MEM, 01 WB)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import legv8_pkg::*;
#(
  parameter int N  = 64,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_d,
  input  logic [3:0]    ALUControl_d,
  input  logic [N-1:0]  readData1_d,
  input  logic [N-1:0]  readData2_d,
  input  logic [N-1:0]  signImm_d,
  input  logic          ALUSrc_d,
  input  logic [RW-1:0] Rn_d,
  input  logic [RW-1:0] Rm_d,
  input  logic [RW-1:0] Rd_d,
  input  logic          RegWrite_d,
  input  logic          MemWrite_d,
  input  logic          MemRead_d,
  input  logic          RegWrite_m,
  input  logic [RW-1:0] Rd_m,
  input  logic [N-1:0]  aluResult_m,
  input  logic          RegWrite_w,
  input  logic [RW-1:0] Rd_w,
  input  logic [N-1:0]  writeData_w,
  output logic [N-1:0]  a_e,
  output logic [N-1:0]  b_e,
  output logic [3:0]    ALUControl_e,
  output logic [N-1:0]  writeData_e,
  output logic [RW-1:0] Rd_e,
  output logic          RegWrite_e,
  output logic          MemWrite_e,
  output logic          MemRead_e,
  output logic          valid_e,
  output logic [1:0]    ForwardA,
  output logic [1:0]    ForwardB
);

  typedef struct packed {
    logic          valid;
    alu_op_t       alu_op;
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [N-1:0]  imm;
    logic          alu_src;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [RW-1:0] rd;
    logic          reg_write;
    logic          mem_write;
    logic          mem_read;
  } stage_t;

  stage_t       stage_d;
  stage_t       stage_q;
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  // Next-state: a flush is a bubble (all zero) and overrides stall.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid     = valid_d;
      stage_d.alu_op    = alu_op_t'(ALUControl_d);
      stage_d.rd1       = readData1_d;
      stage_d.rd2       = readData2_d;
      stage_d.imm       = signImm_d;
      stage_d.alu_src   = ALUSrc_d;
      stage_d.rn        = Rn_d;
      stage_d.rm        = Rm_d;
      stage_d.rd        = Rd_d;
      // An invalid instruction must not cause architectural side effects.
      stage_d.reg_write = valid_d & RegWrite_d;
      stage_d.mem_write = valid_d & MemWrite_d;
      stage_d.mem_read  = valid_d & MemRead_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  forward_unit #(.RW(RW)) u_fwd_a (
    .src         (stage_q.rn),
    .reg_write_m (RegWrite_m),
    .rd_m        (Rd_m),
    .reg_write_w (RegWrite_w),
    .rd_w        (Rd_w),
    .sel         (ForwardA)
  );

  forward_unit #(.RW(RW)) u_fwd_b (
    .src         (stage_q.rm),
    .reg_write_m (RegWrite_m),
    .rd_m        (Rd_m),
    .reg_write_w (RegWrite_w),
    .rd_w        (Rd_w),
    .sel         (ForwardB)
  );

  always_comb begin
    case (fwd_sel_t'(ForwardA))
      FWD_MEM: fwd_a = aluResult_m;
      FWD_WB:  fwd_a = writeData_w;
      default: fwd_a = stage_q.rd1;
    endcase
  end

  always_comb begin
    case (fwd_sel_t'(ForwardB))
      FWD_MEM: fwd_b = aluResult_m;
      FWD_WB:  fwd_b = writeData_w;
      default: fwd_b = stage_q.rd2;
    endcase
  end
`else
  // Hazards are resolved by stalling upstream; MEM/WB data is not needed.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{RegWrite_m, Rd_m, aluResult_m, RegWrite_w,
                               Rd_w, writeData_w, stage_q.rn, stage_q.rm};

  assign ForwardA = FWD_REG;
  assign ForwardB = FWD_REG;
  assign fwd_a    = stage_q.rd1;
  assign fwd_b    = stage_q.rd2;
`endif

  assign a_e          = fwd_a;
  assign b_e          = stage_q.alu_src ? stage_q.imm : fwd_b;
  // Store data always uses the register operand, even for immediate ops.
  assign writeData_e  = fwd_b;
  assign ALUControl_e = stage_q.alu_op;
  assign Rd_e         = stage_q.rd;
  assign RegWrite_e   = stage_q.reg_write;
  assign MemWrite_e   = stage_q.mem_write;
  assign MemRead_e    = stage_q.mem_read;
  assign valid_e      = stage_q.valid;

endmodule

`default_nettype wire
